// File: rtl/blake2_bus_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_bus_host_pkg
//  Description : Shared state encoding, byte-type codes and control bit
//                indices for the Blake2 Pmod bus host.
//  Revision    : 1.0 - initial release
// ============================================================================
package blake2_bus_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_GAP       = 3'd2,
        ST_WAIT_RDY  = 3'd3,
        ST_WAIT_HASH = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [1:0] TYPE_CFG   = 2'b00;
    localparam logic [1:0] TYPE_FIRST = 2'b01;
    localparam logic [1:0] TYPE_DATA  = 2'b10;
    localparam logic [1:0] TYPE_LAST  = 2'b11;

    localparam int CTRL_VALID  = 0;
    localparam int HCTRL_VALID = 0;
    localparam int HCTRL_RDY   = 1;

endpackage
`default_nettype wire

// File: rtl/blake2_bus_host_hash_deser.sv
`default_nettype none
// ============================================================================
//  Module      : hash_deser
//  Description : Collects HASH_BYTES returned hash bytes (byte 0 first) and
//                publishes the digest with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_deser #(
    parameter int HASH_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    last_o,
    output logic [HASH_BYTES*8-1:0] hash_o,
    output logic                    done_o
);
    localparam int CW = $clog2(HASH_BYTES + 1);
    localparam int HW = HASH_BYTES * 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(HASH_BYTES - 1);

    logic [CW-1:0] cnt_q;
    logic [HW-1:0] coll_q;
    logic [HW-1:0] hash_q;
    logic          done_q;

    // The byte completing the digest is the one arriving at the final index.
    assign last_o = byte_valid_i && (cnt_q == CNT_LAST);
    assign hash_o = hash_q;
    assign done_o = done_q;

    // Shift bytes in from the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            coll_q <= '0;
            hash_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (byte_valid_i) begin
                coll_q <= {byte_i, coll_q[HW-1:8]};
                if (last_o) begin
                    cnt_q  <= '0;
                    hash_q <= {byte_i, coll_q[HW-1:8]};
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/blake2_bus_host.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_bus_host
//  Description : Host end of the Blake2 Pmod byte bus. Forwards config and
//                message bytes to the core with block-boundary stalls, then
//                collects the returned digest with a timeout guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module blake2_bus_host
    import blake2_bus_host_pkg::*;
#(
    parameter int HASH_BYTES  = 32,
    parameter int BLOCK_BYTES = 64,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    msg_valid_i,
    output logic                    msg_ready_o,
    input  logic [7:0]              msg_data_i,
    input  logic [1:0]              msg_type_i,
    input  logic                    clr_err_i,
    output logic [7:0]              data_o,
    output logic [2:0]              data_ctrl_o,
    input  logic [7:0]              hash_i,
    input  logic [1:0]              hash_ctrl_i,
    output logic [HASH_BYTES*8-1:0] hash_o,
    output logic                    hash_valid_o,
    output logic                    busy_o,
    output logic                    error_o
);
    localparam int BCW = $clog2(BLOCK_BYTES + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);
    localparam logic [BCW-1:0] BLK_LAST = BCW'(BLOCK_BYTES - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYC - 1);

    state_t               state_q,    state_d;
    logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [GCW-1:0]       gap_cnt_q,  gap_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic [7:0]           data_q,     data_d;
    logic [2:0]           data_ctrl_q, data_ctrl_d;
    logic                 error_q,    error_d;

    logic w_hbyte, w_hrdy, w_accept;
    logic w_send, w_drop, w_stray, w_timeout;
    logic w_deser_last, w_deser_clr, w_deser_valid;

    assign w_hbyte     = hash_ctrl_i[HCTRL_VALID];
    assign w_hrdy      = hash_ctrl_i[HCTRL_RDY];
    assign msg_ready_o = ((state_q == ST_IDLE) || (state_q == ST_SEND)) && w_hrdy;
    assign w_accept    = msg_valid_i && msg_ready_o;

    // The collector only runs while a digest is expected; elsewhere it is
    // held cleared so a later message always starts at index 0.
    assign w_deser_clr   = (state_q != ST_WAIT_HASH);
    assign w_deser_valid = w_hbyte && (state_q == ST_WAIT_HASH);

    hash_deser #(
        .HASH_BYTES (HASH_BYTES)
    ) u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (w_deser_clr),
        .byte_valid_i (w_deser_valid),
        .byte_i       (hash_i),
        .last_o       (w_deser_last),
        .hash_o       (hash_o),
        .done_o       (hash_valid_o)
    );

    // Next-state, counters, bus byte and error flag.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = '0;
        data_d      = data_q;
        data_ctrl_d = data_ctrl_q;
        data_ctrl_d[CTRL_VALID] = 1'b0;
        w_send      = 1'b0;
        w_drop      = 1'b0;
        w_timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (msg_type_i)
                        TYPE_CFG:   w_send = 1'b1;
                        TYPE_FIRST: begin
                            w_send     = 1'b1;
                            byte_cnt_d = BCW'(1);
                            state_d    = ST_SEND;
                        end
                        default:    w_drop = 1'b1;
                    endcase
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    case (msg_type_i)
                        TYPE_DATA: begin
                            w_send = 1'b1;
                            if (byte_cnt_q == BLK_LAST) begin
                                byte_cnt_d = '0;
                                state_d    = ST_GAP;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                        end
                        // The core pads a short final block, and a last byte
                        // that fills a block needs no gap either.
                        TYPE_LAST: begin
                            w_send     = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = ST_WAIT_HASH;
                        end
                        default:   w_drop = 1'b1;
                    endcase
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_WAIT_RDY;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (w_hrdy) begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_HASH: begin
                if (w_deser_last) begin
                    state_d = ST_DONE;
                end else if (w_hbyte) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == '1) begin
                    w_timeout = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (w_send) begin
            data_d                  = msg_data_i;
            data_ctrl_d[2:1]        = msg_type_i;
            data_ctrl_d[CTRL_VALID] = 1'b1;
        end

        w_stray = w_hbyte && (state_q != ST_WAIT_HASH);

        // A new error event takes priority over a simultaneous clear.
        if (w_drop || w_stray || w_timeout) begin
            error_d = 1'b1;
        end else if (clr_err_i) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            data_q      <= '0;
            data_ctrl_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            data_q      <= data_d;
            data_ctrl_q <= data_ctrl_d;
            error_q     <= error_d;
        end
    end

    assign data_o      = data_q;
    assign data_ctrl_o = data_ctrl_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign error_o     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_blake2_bus_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blake2_bus_host
//  Description : Self-checking bench for blake2_bus_host with a transaction
//                level reference model of the byte bus protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blake2_bus_host;
    import blake2_bus_host_pkg::*;

    localparam int HB = 32;
    localparam int BB = 64;
    localparam int GC = 8;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          msg_valid_i;
    logic          msg_ready_o;
    logic [7:0]    msg_data_i;
    logic [1:0]    msg_type_i;
    logic          clr_err_i;
    logic [7:0]    data_o;
    logic [2:0]    data_ctrl_o;
    logic [7:0]    hash_i;
    logic [1:0]    hash_ctrl_i;
    logic [HB*8-1:0] hash_o;
    logic          hash_valid_o;
    logic          busy_o;
    logic          error_o;

    always #5 clk = ~clk;

    blake2_bus_host #(
        .HASH_BYTES  (HB),
        .BLOCK_BYTES (BB),
        .GAP_CYC     (GC),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_valid_i  (msg_valid_i),
        .msg_ready_o  (msg_ready_o),
        .msg_data_i   (msg_data_i),
        .msg_type_i   (msg_type_i),
        .clr_err_i    (clr_err_i),
        .data_o       (data_o),
        .data_ctrl_o  (data_ctrl_o),
        .hash_i       (hash_i),
        .hash_ctrl_i  (hash_ctrl_i),
        .hash_o       (hash_o),
        .hash_valid_o (hash_valid_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic [9:0]      obs_q[$];
    int              hv_pulses;
    logic [HB*8-1:0] hv_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_ctrl_o[0]) obs_q.push_back({data_ctrl_o[2:1], data_o});
            if (hash_valid_o) begin
                hv_pulses++;
                hv_last = hash_o;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [9:0]      exp_q[$];
    logic            mdl_in_msg;   // a first byte has been sent, last not yet
    int              mdl_len;      // message bytes sent in the current message
    logic            mdl_pending;  // a completed block must stall the next byte
    logic            mdl_err;
    logic [HB*8-1:0] mdl_digest;
    int              stalls_seen;

    task automatic mdl_reset();
        mdl_in_msg  = 1'b0;
        mdl_len     = 0;
        mdl_pending = 1'b0;
        mdl_err     = 1'b0;
        mdl_digest  = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Offer one byte, count the stall cycles before it is taken and update
    // the model. ovr >= 0 replaces the model's stall expectation.
    task automatic push(input logic [7:0] d, input logic [1:0] t, input int ovr);
        int   n;
        int   exp_stall;
        logic legal;
        exp_stall   = (ovr >= 0) ? ovr : (mdl_pending ? GC + 1 : 0);
        mdl_pending = 1'b0;
        legal = mdl_in_msg ? (t == TYPE_DATA || t == TYPE_LAST)
                           : (t == TYPE_CFG  || t == TYPE_FIRST);
        msg_valid_i = 1'b1;
        msg_data_i  = d;
        msg_type_i  = t;
        n = 0;
        forever begin
            @(negedge clk);
            if (msg_ready_o) break;
            n++;
            if (n > 200) break;
        end
        @(posedge clk);
        #1;
        msg_valid_i = 1'b0;
        if (n > 0) stalls_seen++;
        check("push_stall", n, exp_stall);
        if (legal) begin
            exp_q.push_back({t, d});
            if (t == TYPE_FIRST) begin
                mdl_in_msg = 1'b1;
                mdl_len    = 1;
            end else if (t == TYPE_DATA) begin
                mdl_len++;
                if (mdl_len % BB == 0) mdl_pending = 1'b1;
            end else if (t == TYPE_LAST) begin
                mdl_in_msg = 1'b0;
            end
        end else begin
            mdl_err = 1'b1;
        end
        check("push_err", error_o, mdl_err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Return n hash bytes: sequential 0,1,2.. or random, optional idle gaps.
    task automatic return_hash(input int n, input logic seq, input logic gaps,
                               output logic [HB*8-1:0] dig);
        dig = '0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = seq ? 8'(i) : 8'($urandom);
            dig[i*8 +: 8] = b;
            hash_i = b;
            hash_ctrl_i[HCTRL_VALID] = 1'b1;
            idle(1);
            hash_ctrl_i[HCTRL_VALID] = 1'b0;
            if (gaps && i < n - 1) idle($urandom_range(0, 2));
        end
    endtask

    task automatic finish_hash(input string pfx, input int p0, input logic [HB*8-1:0] dig);
        idle(2);
        check({pfx, "_pulses"}, hv_pulses, p0 + 1);
        check({pfx, "_digest"}, hv_last, dig);
        check({pfx, "_busy"}, busy_o, 1'b0);
        mdl_digest = dig;
    endtask

    task automatic compare_stream(input string pfx);
        check({pfx, "_stream_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({pfx, "_stream_byte"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_err(input string pfx);
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        mdl_err   = 1'b0;
        check({pfx, "_clr"}, error_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HB*8-1:0] dig;
        int p0, cnt, len, inj;

        rst_n = 1'b0; msg_valid_i = 1'b0; msg_data_i = '0; msg_type_i = '0;
        clr_err_i = 1'b0; hash_i = '0; hash_ctrl_i = '0;
        hv_pulses = 0; hv_last = '0; stalls_seen = 0;
        mdl_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",   data_o, 8'h00);
        check("rst_ctrl",   data_ctrl_o, 3'b000);
        check("rst_hash",   hash_o, '0);
        check("rst_hvalid", hash_valid_o, 1'b0);
        check("rst_busy",   busy_o, 1'b0);
        check("rst_err",    error_o, 1'b0);
        check("rst_ready",  msg_ready_o, 1'b0);
        rst_n = 1'b1;
        idle(1);
        hash_ctrl_i[HCTRL_RDY] = 1'b1;

        // A: config bytes then a 3-byte message, sequential digest
        push(8'h20, TYPE_CFG, -1);
        push(8'h00, TYPE_CFG, -1);
        push(8'h61, TYPE_FIRST, -1);
        push(8'h62, TYPE_DATA, -1);
        push(8'h63, TYPE_LAST, -1);
        check("a_busy_wait", busy_o, 1'b1);
        p0 = hv_pulses;
        return_hash(HB, 1'b1, 1'b0, dig);
        finish_hash("a", p0, dig);
        check("a_byte0",  hv_last[7:0], 8'h00);
        check("a_byte31", hv_last[255:248], 8'h1f);
        compare_stream("a");

        // B: 130-byte message, two block stalls
        stalls_seen = 0;
        push(8'($urandom), TYPE_FIRST, -1);
        for (int i = 1; i < 129; i++) push(8'($urandom), TYPE_DATA, -1);
        push(8'($urandom), TYPE_LAST, -1);
        check("b_stalls", stalls_seen, 2);
        p0 = hv_pulses;
        return_hash(HB, 1'b0, 1'b1, dig);
        finish_hash("b", p0, dig);
        compare_stream("b");

        // C: block boundary with core ready low for 20 cycles
        push(8'($urandom), TYPE_FIRST, -1);
        for (int i = 1; i < BB; i++) push(8'($urandom), TYPE_DATA, -1);
        hash_ctrl_i[HCTRL_RDY] = 1'b0;
        idle(20);
        check("c_busy",  busy_o, 1'b1);
        check("c_ready", msg_ready_o, 1'b0);
        check("c_quiet", obs_q.size(), exp_q.size());
        hash_ctrl_i[HCTRL_RDY] = 1'b1;
        push(8'($urandom), TYPE_LAST, 1);
        p0 = hv_pulses;
        return_hash(HB, 1'b0, 1'b0, dig);
        finish_hash("c", p0, dig);
        compare_stream("c");

        // D: protocol errors and the sticky flag
        push(8'h55, TYPE_DATA, -1);
        check("d_dropped", obs_q.size(), 0);
        clear_err("d1");
        hash_ctrl_i[HCTRL_VALID] = 1'b1;
        clr_err_i = 1'b1;
        idle(1);
        hash_ctrl_i[HCTRL_VALID] = 1'b0;
        clr_err_i = 1'b0;
        check("d_set_wins", error_o, 1'b1);
        clear_err("d2");
        push(8'h11, TYPE_FIRST, -1);
        push(8'h22, TYPE_CFG, -1);
        push(8'h33, TYPE_DATA, -1);
        push(8'h44, TYPE_LAST, -1);
        p0 = hv_pulses;
        return_hash(HB, 1'b0, 1'b0, dig);
        finish_hash("d", p0, dig);
        compare_stream("d");
        clear_err("d3");

        // E: reset during hash collection, then a fresh message
        push(8'h01, TYPE_FIRST, -1);
        push(8'h02, TYPE_LAST, -1);
        p0 = hv_pulses;
        return_hash(10, 1'b0, 1'b0, dig);
        #2;
        rst_n = 1'b0;
        #2;
        check("e_rst_busy", busy_o, 1'b0);
        check("e_rst_hash", hash_o, '0);
        check("e_rst_ctrl", data_ctrl_o, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        idle(1);
        check("e_no_partial", hv_pulses, p0);
        push(8'($urandom), TYPE_FIRST, -1);
        for (int i = 0; i < 4; i++) push(8'($urandom), TYPE_DATA, -1);
        push(8'($urandom), TYPE_LAST, -1);
        p0 = hv_pulses;
        return_hash(HB, 1'b0, 1'b1, dig);
        finish_hash("e", p0, dig);
        compare_stream("e");

        // R: randomized messages with occasional illegal bytes
        for (int m = 0; m < 5; m++) begin
            for (int c = 0; c < int'($urandom_range(0, 2)); c++)
                push(8'($urandom), TYPE_CFG, -1);
            len = $urandom_range(2, 140);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            for (int i = 0; i < len; i++) begin
                if (i == inj) push(8'($urandom), 2'($urandom_range(0, 1)), -1);
                if (!mdl_pending) idle($urandom_range(0, 2));
                push(8'($urandom), (i == 0) ? TYPE_FIRST : (i == len - 1) ? TYPE_LAST : TYPE_DATA, -1);
            end
            p0 = hv_pulses;
            return_hash(HB, 1'b0, 1'b1, dig);
            finish_hash("r", p0, dig);
            compare_stream("r");
            if (mdl_err) clear_err("r");
        end

        // T: last byte sent and no hash returned
        push(8'h5a, TYPE_FIRST, -1);
        push(8'ha5, TYPE_LAST, -1);
        p0  = hv_pulses;
        cnt = 0;
        while (!error_o && cnt < 70000) begin
            idle(1);
            cnt++;
        end
        check("t_window", (cnt >= (1 << TW) - 1) && (cnt <= (1 << TW) + 1), 1'b1);
        check("t_busy",   busy_o, 1'b0);
        check("t_pulses", hv_pulses, p0);
        check("t_hash",   hash_o, mdl_digest);
        compare_stream("t");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blake2_bus_host.md
Name: blake2_bus_host

Overview:
- Host-side end of the Blake2 Pmod byte bus: transmitter for message/config bytes, receiver for hash bytes.
- Drives the 8-bit data bus and the 3-bit data control lines seen by the hash core.
- Collects the returned hash bytes from the 8-bit hash bus and the 2-bit hash control lines.
- Replaces the RPI PIO host for on-FPGA loopback testing; sits between a local byte stream source and the Pmod pins.

Parameters:
- HASH_BYTES, 32, digest length collected per message.
- BLOCK_BYTES, 64, bytes per compression block; host stalls at each block boundary.
- GAP_CYC, 8, cycles held after each block before ready is sampled; covers the round-trip bus register latency.
- TIMEOUT_W, 16, width of the hash wait timeout counter.

Ports:
- clk  in  1  core clock, same domain as the bus registers.
- rst_n  in  1  reset, asynchronous, active-low.
- msg_valid_i  in  1  local byte stream valid.
- msg_ready_o  out  1  local byte stream ready.
- msg_data_i  in  8  message or config byte.
- msg_type_i  in  2  byte type: 00 config, 01 first data, 10 data, 11 last data.
- clr_err_i  in  1  clears the sticky error flag.
- data_o  out  8  bus data byte.
- data_ctrl_o  out  3  bus control: bit 0 valid, bits 2:1 type.
- hash_i  in  8  returned hash byte.
- hash_ctrl_i  in  2  bit 0 hash byte valid, bit 1 core ready.
- hash_o  out  HASH_BYTES*8  collected digest; byte 0 in bits 7:0.
- hash_valid_o  out  1  one-cycle pulse when hash_o is complete.
- busy_o  out  1  high in any state other than IDLE.
- error_o  out  1  sticky protocol or timeout error.

Behaviour:
- Reset: all outputs are 0; state is IDLE; all counters are 0.
- States: IDLE, SEND, GAP, WAIT_RDY, WAIT_HASH, DONE.
- msg_ready_o = (state is IDLE or SEND) and hash_ctrl_i[1].
- Accept means msg_valid_i and msg_ready_o are both high.
- Data output timing:
  - On accept, data_o and data_ctrl_o are registered on the next edge with valid=1 and type=msg_type_i.
  - Valid is 1 for exactly one cycle per accepted byte.
  - data_o holds its last value when idle.
- IDLE:
  - Type 00 bytes are sent; state stays IDLE.
  - Type 01 is sent, byte counter is set to 1, state goes to SEND.
  - Type 10 or 11 in IDLE: byte dropped, error_o set.
- SEND:
  - Each type 10 byte increments the byte counter.
  - Type 01 or 00 in SEND: byte dropped, error_o set.
  - When the counter reaches BLOCK_BYTES it wraps to 0 and state goes to GAP.
  - Type 11 goes to WAIT_HASH; a short final block is legal because the core pads it.
  - A type 11 byte that also completes a block goes to WAIT_HASH, not GAP.
- GAP: counts GAP_CYC cycles, then goes to WAIT_RDY.
- WAIT_RDY: goes to SEND on the first cycle hash_ctrl_i[1]=1.
- WAIT_HASH:
  - Each cycle with hash_ctrl_i[0]=1 shifts hash_i into the collector at index hash_cnt; hash_cnt increments.
  - When hash_cnt reaches HASH_BYTES, hash_o updates and hash_valid_o pulses on the same edge; state goes to DONE.
  - The timeout counter resets on every hash byte.
  - If the timeout counter saturates (2^TIMEOUT_W-1 cycles with no byte), error_o is set and state goes to IDLE; hash_o is unchanged.
- DONE: goes to IDLE after one cycle; msg_ready_o is low in DONE.
- hash_ctrl_i[0]=1 outside WAIT_HASH: byte ignored, error_o set.
- Error flag:
  - error_o is cleared only by rst_n or by clr_err_i.
  - When a set event and clr_err_i coincide, set wins.
- Reset mid-message: everything returns to reset values immediately; no partial hash is flagged.

Decomposition:
- Shared package blake2_bus_host_pkg:
  - state encoding;
  - type codes TYPE_CFG, TYPE_FIRST, TYPE_DATA, TYPE_LAST;
  - control bit indices CTRL_VALID, HCTRL_VALID, HCTRL_RDY.
- Sub-module hash_deser:
  - byte collector with counter, done pulse and clear input;
  - instantiated once; FSM stays in the top module.

Test Plan:
- Config bytes 0x20, 0x00 (type 00), then a 3-byte message 0x61, 0x62, 0x63 (01, 10, 11) -> data_ctrl_o valid pulses carry types 00, 00, 01, 10, 11 with matching data_o; then 32 hash bytes 0x00..0x1F -> hash_valid_o pulses once with hash_o[7:0]=0x00 and hash_o[255:248]=0x1F.
- 130-byte message with core ready held at 1 -> exactly two GAP stalls of 8 cycles, after bytes 64 and 128; then 2 more bytes are sent; msg_ready_o is low during each gap.
- Block boundary with core ready held low for 20 cycles -> host waits in WAIT_RDY; first new byte appears 1 cycle after ready rises.
- Type 10 byte in IDLE -> byte not driven on the bus, error_o=1; clr_err_i pulse -> error_o=0.
- Last byte sent and no hash bytes return -> error_o=1 after 65535 cycles, busy_o returns to 0, hash_valid_o never pulses.
- Reset asserted in WAIT_HASH after 10 hash bytes, then a full new message -> hash_o reflects only the second run's 32 bytes.
